// File: rtl/rvc_instr_decompressor_if.sv
// Bus between the fetch half-word aligner and the RV32C expander:
// one compressed half-word in, one expanded word plus an illegal flag out.
interface rvc_instr_decompressor_if;
  logic [15:0] i_instr;
  logic [31:0] o_instr;
  logic        o_unknown;

  modport master (
    output i_instr,
    input  o_instr,
    input  o_unknown
  );

  modport slave (
    input  i_instr,
    output o_instr,
    output o_unknown
  );
endinterface

// File: rtl/rvc_instr_decompressor.sv
// RV32C -> RV32I instruction expander for the IF->ID align stage.
// Combinational decode with an optional output register (REGISTERED=1).
module rvc_instr_decompressor #(
  parameter bit REGISTERED = 1'b0
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  rvc_instr_decompressor_if.slave   bus
);

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [4:0]  X0         = 5'd0;
  localparam logic [4:0]  X1         = 5'd1;
  localparam logic [4:0]  X2         = 5'd2;

  logic [15:0] c;
  assign c = bus.i_instr;

  // Register fields: full 5-bit in Q1/Q2, 3-bit compressed (x8..x15) otherwise
  logic [4:0] rd;
  logic [4:0] rs2;
  logic [4:0] rs1p;
  logic [4:0] rdp;
  assign rd   = c[11:7];
  assign rs2  = c[6:2];
  assign rs1p = {2'b01, c[9:7]};
  assign rdp  = {2'b01, c[4:2]};

  // Immediates, reassembled from their scattered compressed bit positions
  logic [11:0] imm6_sx;
  logic [11:0] addi4spn_imm;
  logic [11:0] lw_off;
  logic [11:0] addi16sp_imm;
  logic [19:0] lui_imm;
  logic [20:1] j_off;
  logic [19:0] j_imm;
  logic [12:1] b_off;
  logic [11:0] lwsp_off;
  logic [11:0] swsp_off;

  assign imm6_sx      = {{7{c[12]}}, c[6:2]};
  assign addi4spn_imm = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00};
  assign lw_off       = {5'b00000, c[5], c[12:10], c[6], 2'b00};
  assign addi16sp_imm = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000};
  assign lui_imm      = {{15{c[12]}}, c[6:2]};
  assign j_off        = {{9{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3]};
  assign j_imm        = {j_off[20], j_off[10:1], j_off[11], j_off[19:12]};
  assign b_off        = {{5{c[12]}}, c[6:5], c[2], c[11:10], c[4:3]};
  assign lwsp_off     = {4'b0000, c[3:2], c[12], c[6:4], 2'b00};
  assign swsp_off     = {4'b0000, c[8:7], c[12:9], 2'b00};

  logic [31:0] exp_instr;
  logic        illegal;

  always_comb begin
    exp_instr = NOP;
    illegal   = 1'b0;
    case (c[1:0])
      2'b00: begin
        case (c[15:13])
          3'b000: begin
            exp_instr = {addi4spn_imm, X2, 3'b000, rdp, OPC_OP_IMM};
            illegal   = (c[12:5] == 8'h00);
          end
          3'b010:  exp_instr = {lw_off, rs1p, 3'b010, rdp, OPC_LOAD};
          3'b110:  exp_instr = {lw_off[11:5], rdp, rs1p, 3'b010, lw_off[4:0], OPC_STORE};
          default: illegal   = 1'b1;
        endcase
      end

      2'b01: begin
        case (c[15:13])
          3'b000: exp_instr = {imm6_sx, rd, 3'b000, rd, OPC_OP_IMM};
          3'b001: exp_instr = {j_imm, X1, OPC_JAL};
          3'b010: exp_instr = {imm6_sx, X0, 3'b000, rd, OPC_OP_IMM};
          3'b011: begin
            illegal = (c[12] == 1'b0) && (c[6:2] == 5'd0);
            if (rd == X2) begin
              exp_instr = {addi16sp_imm, X2, 3'b000, X2, OPC_OP_IMM};
            end else begin
              exp_instr = {lui_imm, rd, OPC_LUI};
            end
          end
          3'b100: begin
            case (c[11:10])
              2'b00: begin
                exp_instr = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, OPC_OP_IMM};
                illegal   = c[12];
              end
              2'b01: begin
                exp_instr = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, OPC_OP_IMM};
                illegal   = c[12];
              end
              2'b10: exp_instr = {imm6_sx, rs1p, 3'b111, rs1p, OPC_OP_IMM};
              default: begin
                if (c[12]) begin
                  illegal = 1'b1;
                end else begin
                  case (c[6:5])
                    2'b00:   exp_instr = {7'b0100000, rdp, rs1p, 3'b000, rs1p, OPC_OP};
                    2'b01:   exp_instr = {7'b0000000, rdp, rs1p, 3'b100, rs1p, OPC_OP};
                    2'b10:   exp_instr = {7'b0000000, rdp, rs1p, 3'b110, rs1p, OPC_OP};
                    default: exp_instr = {7'b0000000, rdp, rs1p, 3'b111, rs1p, OPC_OP};
                  endcase
                end
              end
            endcase
          end
          3'b101: exp_instr = {j_imm, X0, OPC_JAL};
          // BEQZ/BNEZ differ only in funct3 bit 0, which is c[13]
          default: exp_instr = {b_off[12], b_off[10:5], X0, rs1p, {2'b00, c[13]},
                                b_off[4:1], b_off[11], OPC_BRANCH};
        endcase
      end

      2'b10: begin
        case (c[15:13])
          3'b000: begin
            exp_instr = {7'b0000000, c[6:2], rd, 3'b001, rd, OPC_OP_IMM};
            illegal   = c[12];
          end
          3'b010: begin
            exp_instr = {lwsp_off, X2, 3'b010, rd, OPC_LOAD};
            illegal   = (rd == X0);
          end
          3'b110: exp_instr = {swsp_off[11:5], rs2, X2, 3'b010, swsp_off[4:0], OPC_STORE};
          3'b100: begin
            if (!c[12]) begin
              if (rs2 == X0) begin
                exp_instr = {12'h000, rd, 3'b000, X0, OPC_JALR};
                illegal   = (rd == X0);
              end else begin
                exp_instr = {7'b0000000, rs2, X0, 3'b000, rd, OPC_OP};
              end
            end else begin
              if ((rd == X0) && (rs2 == X0)) begin
                exp_instr = 32'h0010_0073;
              end else if (rs2 == X0) begin
                exp_instr = {12'h000, rd, 3'b000, X1, OPC_JALR};
              end else begin
                exp_instr = {7'b0000000, rs2, rd, 3'b000, rd, OPC_OP};
              end
            end
          end
          default: illegal = 1'b1;
        endcase
      end

      default: illegal = 1'b1;
    endcase
  end

  logic [31:0] dec_instr;
  logic        dec_unknown;
  assign dec_instr   = illegal ? NOP : exp_instr;
  assign dec_unknown = illegal;

  generate
    if (REGISTERED) begin : g_reg
      logic [31:0] instr_q;
      logic        unknown_q;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          instr_q   <= NOP;
          unknown_q <= 1'b0;
        end else begin
          instr_q   <= dec_instr;
          unknown_q <= dec_unknown;
        end
      end

      assign bus.o_instr   = instr_q;
      assign bus.o_unknown = unknown_q;
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = i_clk ^ i_rst;

      assign bus.o_instr   = dec_instr;
      assign bus.o_unknown = dec_unknown;
    end
  endgenerate

endmodule

// File: tb/tb_rvc_instr_decompressor.sv
// Directed bench for rvc_instr_decompressor: combinational and registered
// instances checked against hand-expanded RV32I encodings.
module tb_rvc_instr_decompressor;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  rvc_instr_decompressor_if bus_c ();
  rvc_instr_decompressor_if bus_r ();

  rvc_instr_decompressor #(.REGISTERED(1'b0)) u_comb (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_c.slave)
  );

  rvc_instr_decompressor #(.REGISTERED(1'b1)) u_reg (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_r.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got_i, input logic got_u,
                       input logic [31:0] exp_i, input logic exp_u);
    n_assert++;
    assert ((got_i === exp_i) && (got_u === exp_u)) else begin
      n_fail++;
      $error("FAIL %s: o_instr=%h o_unknown=%b, expected o_instr=%h o_unknown=%b",
             tag, got_i, got_u, exp_i, exp_u);
    end
  endtask

  task automatic comb_vec(input string tag, input logic [15:0] instr,
                          input logic [31:0] exp_i, input logic exp_u);
    bus_c.i_instr = instr;
    #1;
    check(tag, bus_c.o_instr, bus_c.o_unknown, exp_i, exp_u);
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    rst           = 1'b0;
    bus_c.i_instr = 16'h0000;
    bus_r.i_instr = 16'h0040;

    // Registered instance: async reset, mid-run reset, one-cycle latency
    #2 rst = 1'b1;
    #1 check("reg_reset", bus_r.o_instr, bus_r.o_unknown, NOP, 1'b0);
    @(posedge clk); #1;
    check("reg_reset_held", bus_r.o_instr, bus_r.o_unknown, NOP, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reg_addi4spn", bus_r.o_instr, bus_r.o_unknown, 32'h0041_0413, 1'b0);

    #3 rst = 1'b1;
    #1 check("reg_midreset_instr", bus_r.o_instr, bus_r.o_unknown, NOP, 1'b0);

    @(negedge clk);
    rst           = 1'b0;
    bus_r.i_instr = 16'h0000;
    @(posedge clk); #1;
    check("reg_unknown", bus_r.o_instr, bus_r.o_unknown, NOP, 1'b1);

    #3 rst = 1'b1;
    #1 check("reg_midreset_unknown", bus_r.o_instr, bus_r.o_unknown, NOP, 1'b0);

    @(negedge clk);
    rst           = 1'b0;
    bus_r.i_instr = 16'h852E;
    #1 check("reg_mv_before_edge", bus_r.o_instr, bus_r.o_unknown, NOP, 1'b0);
    @(posedge clk); #1;
    check("reg_mv_after_edge", bus_r.o_instr, bus_r.o_unknown, 32'h00B0_0533, 1'b0);

    @(negedge clk);
    bus_r.i_instr = 16'h0003;
    @(posedge clk); #1;
    check("reg_not_compressed", bus_r.o_instr, bus_r.o_unknown, NOP, 1'b1);

    // Combinational instance: one directed vector per encoding class
    comb_vec("c_addi4spn",      16'h0040, 32'h0041_0413, 1'b0);
    comb_vec("c_li_neg1",       16'h557D, 32'hFFF0_0513, 1'b0);
    comb_vec("c_mv",            16'h852E, 32'h00B0_0533, 1'b0);
    comb_vec("c_jr",            16'h8082, 32'h0000_8067, 1'b0);
    comb_vec("c_ebreak",        16'h9002, 32'h0010_0073, 1'b0);
    comb_vec("c_zero",          16'h0000, NOP,           1'b1);
    comb_vec("c_lui_imm0",      16'h6001, NOP,           1'b1);
    comb_vec("c_not_comp",      16'h0003, NOP,           1'b1);
    comb_vec("c_lw",            16'h4144, 32'h0045_2483, 1'b0);
    comb_vec("c_addi_neg3",     16'h10F5, 32'hFFD0_8093, 1'b0);
    comb_vec("c_j_neg2",        16'hBFFD, 32'hFFFF_F06F, 1'b0);
    comb_vec("c_beqz_p8",       16'hC401, 32'h0004_0463, 1'b0);
    comb_vec("c_srai_31",       16'h847D, 32'h41F4_5413, 1'b0);
    comb_vec("c_srli_shamt5",   16'h9001, NOP,           1'b1);
    comb_vec("c_sub",           16'h8C05, 32'h4094_0433, 1'b0);
    comb_vec("c_subw_rsvd",     16'h9C05, NOP,           1'b1);
    comb_vec("c_addi16sp_m16",  16'h717D, 32'hFF01_0113, 1'b0);
    comb_vec("c_lui",           16'h6285, 32'h0000_12B7, 1'b0);
    comb_vec("c_lwsp",          16'h40B2, 32'h00C1_2083, 1'b0);
    comb_vec("c_lwsp_rd0",      16'h4002, NOP,           1'b1);
    comb_vec("c_swsp",          16'hC406, 32'h0011_2423, 1'b0);
    comb_vec("c_add",           16'h952E, 32'h00B5_0533, 1'b0);
    comb_vec("c_jalr",          16'h9282, 32'h0002_80E7, 1'b0);
    comb_vec("c_jr_x0",         16'h8002, NOP,           1'b1);
    comb_vec("c_q0_fp",         16'h2000, NOP,           1'b1);
    comb_vec("c_q2_fp",         16'h2002, NOP,           1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
